// File: rtl/slice_lane_collector.sv
// Collects 64 Keccak slices into a z-indexed buffer and streams the
// transposed state out as 25 lanes in lane order.
module slice_lane_collector #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned LANES  = 25
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         sliceValid,
  input  logic [LANES-1:0]             slice,
  output logic                         sliceReady,
  output logic                         laneValid,
  output logic [SLICES-1:0]            lane,
  output logic [$clog2(LANES)-1:0]     laneIdx,
  output logic                         laneLast,
  input  logic                         laneReady,
  output logic [$clog2(SLICES+1)-1:0]  fill,
  output logic                         busy
);

  localparam int unsigned IW = $clog2(LANES);
  localparam int unsigned FW = $clog2(SLICES + 1);
  localparam int unsigned AW = $clog2(SLICES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } stateT;

  stateT            state;
  logic [LANES-1:0] sliceBuf [SLICES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fill    <= '0;
      laneIdx <= '0;
      for (int unsigned z = 0; z < SLICES; z++) begin
        sliceBuf[z] <= '0;
      end
    end else if (flush) begin
      // Flush wins over any handshake in the same cycle; buffer contents survive.
      state   <= COLLECT;
      fill    <= '0;
      laneIdx <= '0;
    end else begin
      case (state)
        IDLE: state <= COLLECT;
        COLLECT: begin
          if (sliceValid) begin
            sliceBuf[fill[AW-1:0]] <= slice;
            fill <= fill + FW'(1);
            if (fill == FW'(SLICES - 1)) begin
              state   <= EMIT;
              laneIdx <= '0;
            end
          end
        end
        EMIT: begin
          if (laneReady) begin
            if (laneIdx == IW'(LANES - 1)) begin
              state   <= COLLECT;
              fill    <= '0;
              laneIdx <= '0;
            end else begin
              laneIdx <= laneIdx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sliceReady = (state == COLLECT);
  assign laneValid  = (state == EMIT);
  assign busy       = (state == EMIT);
  assign laneLast   = (state == EMIT) && (laneIdx == IW'(LANES - 1));

  // Transpose: lane bit z is the selected lane's bit within slice z.
  always_comb begin
    lane = '0;
    for (int unsigned z = 0; z < SLICES; z++) begin
      lane[z] = sliceBuf[z][laneIdx];
    end
  end

endmodule

// File: tb/tb_slice_lane_collector.sv
// Directed bench for slice_lane_collector: reset, transpose patterns,
// backpressure, flush and mid-frame reset.
module tb_slice_lane_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        sliceValid;
  logic [24:0] slice;
  logic        sliceReady;
  logic        laneValid;
  logic [63:0] lane;
  logic [4:0]  laneIdx;
  logic        laneLast;
  logic        laneReady;
  logic [6:0]  fill;
  logic        busy;

  int nTests = 0;
  int nFail  = 0;

  logic [24:0] model [64];

  slice_lane_collector #(.SLICES(64), .LANES(25)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .sliceValid (sliceValid),
    .slice      (slice),
    .sliceReady (sliceReady),
    .laneValid  (laneValid),
    .lane       (lane),
    .laneIdx    (laneIdx),
    .laneLast   (laneLast),
    .laneReady  (laneReady),
    .fill       (fill),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expLane(input int x);
    logic [63:0] r;
    r = '0;
    for (int z = 0; z < 64; z++) r[z] = model[z][x];
    return r;
  endfunction

  task automatic sendSlices(input string tag, input int n);
    for (int z = 0; z < n; z++) begin
      sliceValid = 1'b1;
      slice      = model[z];
      step();
      if (z < 63) check({tag, " fill"}, 64'(fill), 64'(z + 1));
    end
    sliceValid = 1'b0;
  endtask

  task automatic runFrame(input string tag, input int stallAt, input bit offer);
    if (offer) begin
      sliceValid = 1'b1;
      slice      = '1;
    end
    for (int i = 0; i < 25; i++) begin
      check({tag, " laneValid"}, 64'(laneValid), 64'(1));
      check({tag, " busy"}, 64'(busy), 64'(1));
      check({tag, " sliceReady"}, 64'(sliceReady), 64'(0));
      check({tag, " laneIdx"}, 64'(laneIdx), 64'(i));
      check({tag, " laneLast"}, 64'(laneLast), 64'(i == 24));
      check({tag, " lane"}, lane, expLane(i));
      check({tag, " fill"}, 64'(fill), 64'(64));
      if (i == stallAt) begin
        laneReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          check({tag, " stall laneIdx"}, 64'(laneIdx), 64'(i));
          check({tag, " stall lane"}, lane, expLane(i));
          check({tag, " stall fill"}, 64'(fill), 64'(64));
        end
      end
      laneReady = 1'b1;
      step();
    end
    sliceValid = 1'b0;
    laneReady  = 1'b0;
    check({tag, " end sliceReady"}, 64'(sliceReady), 64'(1));
    check({tag, " end laneValid"}, 64'(laneValid), 64'(0));
    check({tag, " end fill"}, 64'(fill), 64'(0));
  endtask

  initial begin
    int cnt;
    int cyc;

    rst = 1'b1; flush = 1'b0; sliceValid = 1'b0; slice = '0; laneReady = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst sliceReady", 64'(sliceReady), 64'(0));
    check("rst laneValid", 64'(laneValid), 64'(0));
    check("rst laneIdx", 64'(laneIdx), 64'(0));
    check("rst laneLast", 64'(laneLast), 64'(0));
    check("rst fill", 64'(fill), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst lane", lane, 64'h0);
    rst = 1'b0;
    check("idle sliceReady", 64'(sliceReady), 64'(0));
    step();
    check("collect sliceReady", 64'(sliceReady), 64'(1));

    // Diagonal pattern
    for (int z = 0; z < 64; z++) model[z] = 25'h1 << (z % 25);
    sendSlices("diag", 64);
    check("diag latency laneValid", 64'(laneValid), 64'(1));
    check("diag lane0 const", lane, 64'h0004000002000001);
    laneReady = 1'b1;
    repeat (13) step();
    check("diag lane13 const", lane, 64'h8000004000002000);
    repeat (11) step();
    check("diag lane24 idx", 64'(laneIdx), 64'(24));
    check("diag lane24 const", lane, 64'h0002000001000000);
    check("diag lane24 last", 64'(laneLast), 64'(1));
    step();
    laneReady = 1'b0;
    check("diag done sliceReady", 64'(sliceReady), 64'(1));
    check("diag done laneValid", 64'(laneValid), 64'(0));
    check("diag done fill", 64'(fill), 64'(0));

    // Gapped input, stall at lane 7, slices offered throughout EMIT
    for (int z = 0; z < 64; z++) model[z] = 25'h1555555 ^ (25'(z) << 7) ^ 25'(z * 3);
    cnt = 0;
    cyc = 0;
    while (cnt < 64 && cyc < 200) begin
      sliceValid = (cyc % 2 == 0);
      slice      = sliceValid ? model[cnt] : 25'h0ABCDEF;
      step();
      if (sliceValid) cnt++;
      check("gap fill", 64'(fill), 64'(cnt));
      cyc++;
    end
    sliceValid = 1'b0;
    runFrame("gap", 7, 1'b1);

    // Flush after 30 slices, with a slice offered on the flush cycle
    for (int z = 0; z < 64; z++) model[z] = 25'(z + 1);
    sendSlices("preflush", 30);
    flush = 1'b1; sliceValid = 1'b1; slice = 25'h1234567;
    step();
    flush = 1'b0; sliceValid = 1'b0;
    check("flush fill", 64'(fill), 64'(0));
    check("flush sliceReady", 64'(sliceReady), 64'(1));
    check("flush laneValid", 64'(laneValid), 64'(0));
    for (int z = 0; z < 64; z++) model[z] = 25'h1FFFFFF;
    sendSlices("ones", 64);
    for (int i = 0; i < 25; i++) begin
      check("ones lane", lane, 64'hFFFFFFFFFFFFFFFF);
      laneReady = 1'b1;
      step();
    end
    laneReady = 1'b0;
    check("ones done fill", 64'(fill), 64'(0));

    // Reset mid-emit at laneIdx 10
    for (int z = 0; z < 64; z++) model[z] = 25'(z * 32'h00B3A5F1);
    sendSlices("pre-rst", 64);
    laneReady = 1'b1;
    repeat (10) step();
    check("pre-rst laneIdx", 64'(laneIdx), 64'(10));
    check("pre-rst lane", lane, expLane(10));
    rst = 1'b1;
    #1;
    check("async rst laneValid", 64'(laneValid), 64'(0));
    check("async rst lane", lane, 64'h0);
    check("async rst laneIdx", 64'(laneIdx), 64'(0));
    check("async rst fill", 64'(fill), 64'(0));
    check("async rst busy", 64'(busy), 64'(0));
    laneReady = 1'b0;
    step();
    rst = 1'b0;
    check("post-rst idle sliceReady", 64'(sliceReady), 64'(0));
    step();
    check("post-rst sliceReady", 64'(sliceReady), 64'(1));
    check("post-rst laneValid", 64'(laneValid), 64'(0));
    for (int z = 0; z < 64; z++) model[z] = 25'h1 << ((z * 7) % 25);
    sendSlices("refill", 64);
    runFrame("refill", -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/slice_lane_collector.md
# slice_lane_collector

Reassembles the Keccak-f[1600] state after the slice-oriented datapath has processed it. The block accepts 64 consecutive 25-bit slices (z = 0..63) and buffers them. It then transposes the buffer and emits the 25 64-bit lanes in lane order for the lane-oriented side of the design: the rotate/iota stages and state write-back. It is the reader end of the datapath's slice output, and the counterpart of the lane-to-slice feeder.

## Interface
- `SLICES`, 64, number of slices per state (lane width in bits).
- `LANES`, 25, number of lanes per state (slice width in bits).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of counters; returns the block to COLLECT.
- `sliceValid` in 1: `slice` holds a valid slice.
- `slice` in 25: slice bit `5*y+x` is A[x,y,z] for the current z.
- `sliceReady` out 1: block accepts a slice this cycle.
- `laneValid` out 1: `lane` is valid.
- `lane` out 64: lane bit z is A[x,y,z] for lane index `5*y+x`.
- `laneIdx` out 5: index (0..24) of the lane presented.
- `laneLast` out 1: high with `laneValid` when `laneIdx` = 24.
- `laneReady` in 1: consumer takes the lane this cycle.
- `fill` out 7: number of slices currently buffered (0..64).
- `busy` out 1: high in EMIT.

## Operation
- Storage is a 64 x 25 register array, `buf[z]`. `lane[z]` = `buf[z][laneIdx]` for z = 0..63; this output mux is combinational.
- FSM states are IDLE, COLLECT and EMIT. Reset state is IDLE.
- IDLE goes to COLLECT unconditionally on the next edge.
- COLLECT:
  - `sliceReady`=1.
  - On `sliceValid & sliceReady`: `buf[fill]` <= `slice`, then `fill` <= `fill`+1.
  - When slice 63 is accepted, `fill` becomes 64 and the state goes to EMIT with `laneIdx`=0.
- EMIT:
  - `sliceReady`=0, `laneValid`=1, `busy`=1.
  - On `laneValid & laneReady`: `laneIdx` <= `laneIdx`+1.
  - When `laneIdx`=24 is accepted: state goes to COLLECT, `fill` <= 0, `laneIdx` <= 0.
- Slices offered during EMIT are ignored: no buffer write, and `fill` does not change.
- `flush` (any state except while `rst` is asserted) sets `fill`=0 and `laneIdx`=0 and moves the state to COLLECT on the next edge. It does not clear `buf` contents. `flush` has priority over a simultaneous slice or lane handshake, and that handshake is dropped.
- `fill` saturates at 64. It never wraps, because `sliceReady` is 0 whenever `fill`=64.
- `laneIdx` never exceeds 24. There is no wrap past 24 except through the EMIT->COLLECT transition.

## Timing
- Reset values while `rst`=1 (asserted asynchronously):
  - `sliceReady`=0, `laneValid`=0, `laneIdx`=0, `laneLast`=0, `fill`=0, `busy`=0.
  - `buf` is all zeros, so `lane`=0.
- After `rst` deasserts: one cycle in IDLE, then `sliceReady`=1 from the second edge.
- Reset asserted mid-frame aborts immediately. Outputs take their reset values in the same cycle and no partial lane stream resumes.
- Input throughput is one slice per cycle.
- Latency: the edge that accepts slice 63 makes `laneValid`=1 in the next cycle, carrying lane 0.
- Output throughput is one lane per cycle while `laneReady`=1.
- Backpressure: while `laneValid & ~laneReady`, `lane`, `laneIdx` and `laneLast` stay stable.
- Minimum frame period is 64 + 25 = 89 cycles.
- `sliceReady` returns to 1 in the cycle after lane 24 is accepted.

## Test plan
- Reset: hold `rst` 3 cycles -> all outputs 0 during reset; `sliceReady`=0 in the first cycle after release and 1 in the second.
- Diagonal pattern: send slice z = `25'h1 << (z % 25)` for z = 0..63 with `laneReady`=1 -> the following lanes appear on consecutive cycles, with `laneLast` only on lane 24:
  - lane 0 = `64'h0004000002000001`
  - lane 13 = `64'h8000004000002000`
  - lane 24 = `64'h0002000001000000`
- Backpressure and gaps:
  - Toggle `sliceValid` every other cycle -> `fill` counts only handshakes.
  - Hold `laneReady`=0 for 5 cycles at `laneIdx`=7 -> `lane` and `laneIdx` are unchanged for those 5 cycles.
  - Offer `sliceValid`=1 throughout EMIT -> `fill` stays at 64 and `buf` is unchanged.
- Flush: assert `flush` after 30 slices -> `fill`=0 next cycle. Then send 64 slices of `25'h1FFFFFF` -> all 25 lanes = `64'hFFFFFFFFFFFFFFFF`.
- Reset mid-emit: assert `rst` at `laneIdx`=10 -> `laneValid`=0 and `lane`=0 in the same cycle. After release, a new full frame is emitted correctly from lane 0.
